// File: rtl/cardio_feature_loader.sv
// cardio_feature_loader
// Front end for the combinational BNN classifier cardio_bp. It collects N
// B-bit features from a valid/ready stream and packs them into one flat
// vector. It holds that vector while the classifier settles, then samples
// the class index and offers it on a valid/ready result port.
// Optional build macro LOADER_FRAMECHK_EN: checks feat_last on every
// accepted beat. A misplaced flag drops the frame and pulses frame_err.
module cardio_feature_loader #(
    parameter int N      = 19,
    parameter int B      = 4,
    parameter int C      = 3,
    parameter int SETTLE = 2,
    parameter int FCW    = 16,
    localparam int KW    = (C > 1) ? $clog2(C) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             feat_valid,
    output logic             feat_ready,
    input  logic [B-1:0]     feat_data,
    input  logic             feat_last,
    output logic [N*B-1:0]   inp_vec,
    input  logic [KW-1:0]    klass_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [KW-1:0]    res_klass,
    output logic             busy,
    output logic             frame_err,
    output logic [FCW-1:0]   frames_done
);

    localparam int BCW = (N > 1) ? $clog2(N) : 1;
    localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_RESULT  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [BCW-1:0]   beat_q, beat_d;
    logic [SCW-1:0]   settle_q, settle_d;
    logic [N*B-1:0]   inp_vec_q, inp_vec_d;
    logic [KW-1:0]    res_klass_q, res_klass_d;
    logic             res_valid_q, res_valid_d;
    logic             feat_ready_q, feat_ready_d;
    logic             busy_q, busy_d;
    logic             frame_err_q, frame_err_d;
    logic [FCW-1:0]   frames_done_q, frames_done_d;

    logic             beat_acc_s;
    logic             last_pos_s;
    logic             hs_s;
    logic             bad_s;

    assign beat_acc_s = feat_valid && feat_ready_q;
    assign last_pos_s = (beat_q == BCW'(N - 1));
    assign hs_s       = res_valid_q && res_ready;

`ifdef LOADER_FRAMECHK_EN
    // A frame is malformed when feat_last disagrees with the beat position.
    assign bad_s = beat_acc_s && (feat_last != last_pos_s);
`else
    // Frames are delimited by count alone, so feat_last is not used.
    logic unused_feat_last_s;
    assign unused_feat_last_s = feat_last;
    assign bad_s = 1'b0;
`endif

    // State and datapath registers; async reset puts the loader back in COLLECT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_COLLECT;
            beat_q        <= {BCW{1'b0}};
            settle_q      <= {SCW{1'b0}};
            inp_vec_q     <= {(N*B){1'b0}};
            res_klass_q   <= {KW{1'b0}};
            res_valid_q   <= 1'b0;
            feat_ready_q  <= 1'b1;
            busy_q        <= 1'b0;
            frame_err_q   <= 1'b0;
            frames_done_q <= {FCW{1'b0}};
        end else begin
            state_q       <= state_d;
            beat_q        <= beat_d;
            settle_q      <= settle_d;
            inp_vec_q     <= inp_vec_d;
            res_klass_q   <= res_klass_d;
            res_valid_q   <= res_valid_d;
            feat_ready_q  <= feat_ready_d;
            busy_q        <= busy_d;
            frame_err_q   <= frame_err_d;
            frames_done_q <= frames_done_d;
        end
    end

    // Next-state: collect N beats, wait out the settle time, then hold the result until it is taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_COLLECT: begin
                if (beat_acc_s && !bad_s && last_pos_s) begin
                    state_d = ST_SETTLE;
                end else begin
                    state_d = ST_COLLECT;
                end
            end
            ST_SETTLE: begin
                if (settle_q == {SCW{1'b0}}) begin
                    state_d = ST_RESULT;
                end else begin
                    state_d = ST_SETTLE;
                end
            end
            ST_RESULT: begin
                if (hs_s) begin
                    state_d = ST_COLLECT;
                end else begin
                    state_d = ST_RESULT;
                end
            end
            default: state_d = ST_COLLECT;
        endcase
    end

    // Datapath and output next values; ready and busy follow the upcoming state so they stay registered.
    always_comb begin
        beat_d        = beat_q;
        settle_d      = settle_q;
        inp_vec_d     = inp_vec_q;
        res_klass_d   = res_klass_q;
        res_valid_d   = res_valid_q;
        frame_err_d   = 1'b0;
        frames_done_d = frames_done_q;
        case (state_q)
            ST_COLLECT: begin
                if (beat_acc_s) begin
                    inp_vec_d = {inp_vec_q[N*B-B-1:0], feat_data};
                    if (bad_s) begin
                        beat_d      = {BCW{1'b0}};
                        frame_err_d = 1'b1;
                    end else if (last_pos_s) begin
                        beat_d   = {BCW{1'b0}};
                        settle_d = SCW'(SETTLE - 1);
                    end else begin
                        beat_d = beat_q + BCW'(1);
                    end
                end else begin
                    beat_d = beat_q;
                end
            end
            ST_SETTLE: begin
                if (settle_q == {SCW{1'b0}}) begin
                    res_klass_d = klass_in;
                    res_valid_d = 1'b1;
                end else begin
                    settle_d = settle_q - SCW'(1);
                end
            end
            ST_RESULT: begin
                if (hs_s) begin
                    res_valid_d   = 1'b0;
                    frames_done_d = frames_done_q + FCW'(1);
                end else begin
                    res_valid_d = res_valid_q;
                end
            end
            default: begin
                beat_d      = {BCW{1'b0}};
                res_valid_d = 1'b0;
            end
        endcase
        feat_ready_d = (state_d == ST_COLLECT);
        busy_d       = (state_d != ST_COLLECT);
    end

    assign feat_ready  = feat_ready_q;
    assign inp_vec     = inp_vec_q;
    assign res_valid   = res_valid_q;
    assign res_klass   = res_klass_q;
    assign busy        = busy_q;
    assign frame_err   = frame_err_q;
    assign frames_done = frames_done_q;

endmodule

// File: doc/cardio_feature_loader.md
Name: cardio_feature_loader

Overview:
Upstream stage for the combinational BNN classifier `cardio_bp`. It accepts one B-bit quantised feature per beat over a valid/ready stream and packs N features into the flat N*B input vector. It holds that vector stable while the classifier settles, then samples the class index and returns it on a valid/ready result interface.

Parameters:
N, 19, features per frame
B, 4, bits per feature
C, 3, number of classes; class width KW = $clog2(C)
SETTLE, 2, cycles `inp_vec` is held before `klass_in` is sampled; minimum 1
FCW, 16, width of the completed-frame counter

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
feat_valid  input  1  feature beat valid
feat_ready  output  1  loader can accept a feature
feat_data  input  B  feature value
feat_last  input  1  marks the last feature of a frame; used only with LOADER_FRAMECHK_EN
inp_vec  output  N*B  packed vector to the classifier's `inp`
klass_in  input  KW  classifier's `klass` output
res_valid  output  1  result valid
res_ready  input  1  result consumer ready
res_klass  output  KW  sampled class
busy  output  1  high in SETTLE or RESULT
frame_err  output  1  one-cycle framing error pulse
frames_done  output  FCW  count of completed result handshakes; wraps modulo 2^FCW

Behaviour:
- Reset (async assert, sync release):
  - state = COLLECT
  - `inp_vec`, `res_klass`, `frames_done`, beat counter and settle counter = 0
  - `res_valid` = 0, `frame_err` = 0, `busy` = 0
  - `feat_ready` = 1 from the first cycle after reset
- States: COLLECT, SETTLE, RESULT.
- COLLECT:
  - `feat_ready` = 1.
  - Each accepted beat (`feat_valid` && `feat_ready`) does `inp_vec <= {inp_vec[N*B-B-1:0], feat_data}` and beat counter +1.
  - After N beats the first feature received occupies `inp_vec[N*B-1 -: B]` and the last occupies `[B-1:0]`.
  - On the beat accepted with counter == N-1: counter <= 0, settle counter <= SETTLE-1, go to SETTLE.
- SETTLE:
  - `feat_ready` = 0; `inp_vec` frozen.
  - Settle counter decrements each cycle.
  - On the cycle the counter is 0: `res_klass <= klass_in`, `res_valid <= 1`, go to RESULT.
  - Latency: last beat accepted at edge k → `res_valid` high after edge k+SETTLE.
- RESULT:
  - `feat_ready` = 0.
  - `res_valid` and `res_klass` held stable until `res_ready`.
  - On handshake: `res_valid <= 0`, `frames_done` +1, go to COLLECT.
  - `feat_ready` rises the cycle after the handshake; no beat is accepted in the handshake cycle.
- `inp_vec` is valid only in SETTLE and RESULT. It shifts freely during COLLECT; the downstream classifier output is ignored then.
- `feat_valid` while `feat_ready` = 0: beat not consumed; the producer must hold it.
- `res_ready` asserted outside RESULT: ignored.
- Reset mid-frame: partial frame discarded; no result produced.
- `frames_done` wraps from 2^FCW-1 to 0.

Optional Feature:
LOADER_FRAMECHK_EN defined:
- `feat_last` is checked on every accepted beat.
- `feat_last` = 1 with counter != N-1, or `feat_last` = 0 with counter == N-1:
  - `frame_err` pulses high for 1 cycle.
  - Beat counter <= 0; state stays COLLECT; frame dropped; no SETTLE entered.
  - `inp_vec` is not cleared; the next frame overwrites it.
- A correct `feat_last` on beat N-1 proceeds as normal.

Not defined:
- `feat_last` ignored; `frame_err` tied 0; frames delimited purely by count.

Test Plan:
1. Reset, then stream the 19 nibbles of 76'h4000d18100621208964 MSB-first, valid every cycle; classifier stub klass_in = 2 → `inp_vec` = 76'h4000d18100621208964 in SETTLE; `res_valid` high 2 cycles after the last beat with `res_klass` = 2; `feat_ready` low until the result is accepted.
2. Hold `res_ready` = 0 for 10 cycles, then 1 → `res_valid`/`res_klass` stable throughout; `frames_done` 0→1 after the handshake; `feat_ready` = 1 the next cycle.
3. Back-to-back frames using vectors 76'h8203140320b3a52a991 and 76'h8104150720a07a0a991, with random `feat_valid` gaps and `res_ready` tied 1 → each `inp_vec` matches its vector; two results; `frames_done` = 2.
4. Assert `rst_n` = 0 after 7 beats, release, send a full frame of 76'h8203150600a0780a991 → exactly one result, for the new frame only.
5. With LOADER_FRAMECHK_EN: `feat_last` = 1 on beat 5 → `frame_err` 1-cycle pulse, no `res_valid`; the following correct frame produces a normal result. Without the macro: same stimulus → `frame_err` stays 0; the frame completes after 19 beats.
6. Preload `frames_done` to 16'hFFFF via 65535 frames (or force), complete one more frame → `frames_done` = 0.
